// File: rtl/icache_line_refill.sv
`default_nettype none
// ============================================================================
// Module   : icache_line_refill
// Function : I-cache miss refill. Issues one burst read, assembles the beats
//            into a line, then writes the data and tag memories in one cycle.
// Revision : 1.0
// ============================================================================
module icache_line_refill #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LINE_WIDTH    = 512,
    parameter int BEAT_WIDTH    = 32,
    parameter int SET_COUNT     = 512,
    localparam int OFFSET_BITS  = $clog2(LINE_WIDTH / 8),
    localparam int INDEX_BITS   = $clog2(SET_COUNT),
    localparam int TAG_BITS     = ADDRESS_WIDTH - INDEX_BITS - OFFSET_BITS
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     MISS_VALID,
    input  logic [ADDRESS_WIDTH-1:0] MISS_ADDRESS,
    output logic                     MISS_READY,
    output logic                     MEM_REQ_VALID,
    output logic [ADDRESS_WIDTH-1:0] MEM_REQ_ADDRESS,
    input  logic                     MEM_REQ_READY,
    input  logic                     MEM_RESP_VALID,
    input  logic [BEAT_WIDTH-1:0]    MEM_RESP_DATA,
    output logic [INDEX_BITS-1:0]    DATA_WRITE_ADDRESS,
    output logic [LINE_WIDTH-1:0]    DATA_WRITE_DATA,
    output logic                     DATA_WRITE_ENABLE,
    output logic [TAG_BITS:0]        TAG_WRITE_DATA,
    output logic                     TAG_WRITE_ENABLE,
    output logic                     REFILL_DONE,
    output logic                     BUSY
);

    localparam int c_BEATS      = LINE_WIDTH / BEAT_WIDTH;
    localparam int c_BEAT_CNT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_LINE_ADR_W = ADDRESS_WIDTH - OFFSET_BITS;
    localparam logic [c_BEAT_CNT_W-1:0] c_LAST_BEAT = c_BEAT_CNT_W'(c_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQUEST = 2'd1,
        S_RECEIVE = 2'd2,
        S_WRITE   = 2'd3
    } state_t;

    state_t                    r_state;
    logic [c_BEAT_CNT_W-1:0]   r_beat;
    logic [LINE_WIDTH-1:0]     r_line;
    logic [c_LINE_ADR_W-1:0]   r_line_addr;
    logic                      r_miss_ready;
    logic                      r_req_valid;
    logic                      r_write;
    logic                      r_busy;

    // Byte offset within the line is irrelevant: the whole line is refilled.
    logic w_unused_offset;
    assign w_unused_offset = ^MISS_ADDRESS[OFFSET_BITS-1:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_beat       <= '0;
            r_line       <= '0;
            r_line_addr  <= '0;
            r_miss_ready <= 1'b1;
            r_req_valid  <= 1'b0;
            r_write      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (MISS_VALID) begin
                        r_line_addr  <= MISS_ADDRESS[ADDRESS_WIDTH-1:OFFSET_BITS];
                        r_beat       <= '0;
                        r_state      <= S_REQUEST;
                        r_miss_ready <= 1'b0;
                        r_req_valid  <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_REQUEST: begin
                    if (MEM_REQ_READY) begin
                        r_state     <= S_RECEIVE;
                        r_req_valid <= 1'b0;
                    end
                end
                S_RECEIVE: begin
                    if (MEM_RESP_VALID) begin
                        r_line[r_beat*BEAT_WIDTH +: BEAT_WIDTH] <= MEM_RESP_DATA;
                        if (r_beat == c_LAST_BEAT) begin
                            r_beat  <= '0;
                            r_state <= S_WRITE;
                            r_write <= 1'b1;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_state      <= S_IDLE;
                    r_miss_ready <= 1'b1;
                    r_busy       <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_miss_ready <= 1'b1;
                    r_req_valid  <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    // Write-port payload comes straight from registers; only the enables qualify it.
    assign MISS_READY         = r_miss_ready;
    assign MEM_REQ_VALID      = r_req_valid;
    assign MEM_REQ_ADDRESS    = {r_line_addr, {OFFSET_BITS{1'b0}}};
    assign DATA_WRITE_ADDRESS = r_line_addr[INDEX_BITS-1:0];
    assign DATA_WRITE_DATA    = r_line;
    assign DATA_WRITE_ENABLE  = r_write;
    assign TAG_WRITE_DATA     = {1'b1, r_line_addr[c_LINE_ADR_W-1 -: TAG_BITS]};
    assign TAG_WRITE_ENABLE   = r_write;
    assign REFILL_DONE        = r_write;
    assign BUSY               = r_busy;

endmodule
`default_nettype wire
